// File: rtl/conv32_8_sched_if.sv
// Bundle of signals between the lane sources, the conv32_8 serializer and the
// round-robin scheduler.
//   master : scheduler view (drives grants, the word to conv32_8 and tag outputs)
//   slave  : environment view (lanes + conv32_8 byte-valid)
// Signals:
//   req_valid/req_data/req_ready : per-lane word handshake (lane i at bits [32*i+31:32*i])
//   in_data32/in32               : word and word-valid to conv32_8
//   out8                         : conv32_8 byte-valid
//   out_tag/out_tag_valid        : lane index of the current output byte
//   err_orphan                   : sticky flag, byte seen with no word in flight
interface conv32_8_sched_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned TAG_W = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [32*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic [31:0]         in_data32;
  logic                in32;
  logic                out8;
  logic [TAG_W-1:0]    out_tag;
  logic                out_tag_valid;
  logic                err_orphan;

  modport master (
    input  req_valid, req_data, out8,
    output req_ready, in_data32, in32, out_tag, out_tag_valid, err_orphan
  );

  modport slave (
    output req_valid, req_data, out8,
    input  req_ready, in_data32, in32, out_tag, out_tag_valid, err_orphan
  );
endinterface

// File: rtl/conv32_8_sched.sv
// Round-robin scheduler sharing one conv32_8 (32->8 serializer) among N_REQ
// lanes. Runs at the clk_4f rate, issues at most one word per 4-cycle frame
// (arbitration only in phase 3) and tags every serialized byte with its lane.
// Ports:
//   clk   : clk_4f-rate clock
//   reset : asynchronous, active-low
//   bus   : conv32_8_sched_if.master (lane handshake, conv32_8 side, tag outputs)
module conv32_8_sched #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned TAG_W    = 2,
  parameter int unsigned TAGQ_DEP = 4
) (
  input logic              clk,
  input logic              reset,
  conv32_8_sched_if.master bus
);

  localparam int unsigned PTR_W = (TAGQ_DEP > 1) ? $clog2(TAGQ_DEP) : 1;
  localparam int unsigned CNT_W = $clog2(TAGQ_DEP + 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [31:0]      data_q, data_nxt;
  logic [1:0]       phase;
  logic [TAG_W-1:0] rr_ptr;
  logic [TAG_W-1:0] tag_mem [TAGQ_DEP];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [1:0]       byte_cnt;
  logic             err_q;
  logic             q_empty, q_full, pop, push, can_grant, hit;
  logic [TAG_W-1:0] grant_idx;
  logic [N_REQ-1:0] grant_oh;

  // First valid lane after ptr (wrapping); returns {hit, index}.
  function automatic logic [TAG_W:0] pick(input logic [N_REQ-1:0] v,
                                          input logic [TAG_W-1:0] ptr);
    logic             found;
    logic [TAG_W-1:0] idx;
    logic [N_REQ-1:0] sh;
    int unsigned      j;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      j  = (32'(ptr) + k) % N_REQ;
      sh = v >> j;
      if (!found && sh[0]) begin
        found = 1'b1;
        idx   = TAG_W'(j);
      end
    end
    return {found, idx};
  endfunction

  // Tag queue status; the 4th byte of a word retires its tag.
  assign q_empty   = (count == '0);
  assign q_full    = (count == CNT_W'(TAGQ_DEP));
  assign pop       = bus.out8 && !q_empty && (byte_cnt == 2'd3);
  assign can_grant = !q_full || pop;

  // Phase-3 arbitration; the grant is the handshake cycle.
  always_comb begin
    {hit, grant_idx} = pick(bus.req_valid, rr_ptr);
    push     = (phase == 2'd3) && hit && can_grant;
    grant_oh = push ? (N_REQ'(1) << grant_idx) : '0;
  end

  // FSM state register (also holds the word presented to conv32_8).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      data_q <= '0;
    end else begin
      state  <= state_nxt;
      data_q <= data_nxt;
    end
  end

  // Next state: the word only changes at the edge that ends phase 3.
  always_comb begin
    state_nxt = state;
    data_nxt  = data_q;
    if (phase == 2'd3) begin
      if (push) begin
        state_nxt = ACTIVE;
        data_nxt  = 32'(bus.req_data >> (32'(grant_idx) * 32'd32));
      end else begin
        state_nxt = IDLE;
        data_nxt  = '0;
      end
    end
  end

  // Frame phase, round-robin pointer, tag queue, byte counter, orphan flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase    <= 2'd0;
      rr_ptr   <= TAG_W'(N_REQ - 1);
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      byte_cnt <= 2'd0;
      err_q    <= 1'b0;
      for (int unsigned i = 0; i < TAGQ_DEP; i++) tag_mem[i] <= '0;
    end else begin
      phase <= phase + 2'd1;
      if (push) begin
        rr_ptr          <= grant_idx;
        tag_mem[wr_ptr] <= grant_idx;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      // Orphan bytes do not advance the byte count.
      if (bus.out8 && !q_empty) byte_cnt <= byte_cnt + 2'd1;
      if (bus.out8 && q_empty)  err_q    <= 1'b1;
    end
  end

  assign bus.req_ready     = grant_oh;
  assign bus.in_data32     = data_q;
  assign bus.in32          = (state == ACTIVE);
  assign bus.out_tag       = tag_mem[rd_ptr];
  assign bus.out_tag_valid = bus.out8 && !q_empty;
  assign bus.err_orphan    = err_q;

endmodule

// File: tb/tb_conv32_8_sched.sv
// Directed bench for conv32_8_sched with a reference model of the scheduler,
// a stand-in conv32_8 (byte-valid = in32 delayed one cycle) and a tag scoreboard.
module tb_conv32_8_sched;
  localparam int N_REQ    = 4;
  localparam int TAG_W    = 2;
  localparam int TAGQ_DEP = 4;
  localparam int DW       = 32 * N_REQ;

  logic clk;
  logic rst_n;

  conv32_8_sched_if #(.N_REQ(N_REQ), .TAG_W(TAG_W)) bus ();

  conv32_8_sched #(.N_REQ(N_REQ), .TAG_W(TAG_W), .TAGQ_DEP(TAGQ_DEP)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // reference model state
  int          m_ph, m_rr, m_bcnt;
  bit          m_in32, m_orphan;
  logic [31:0] m_data;
  int          tag_q[$];
  int          dut_grants[$];
  int          tv_cnt;

  // converter stand-in
  bit conv_en, out8_man, prev_in32;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int lane, input logic [31:0] w);
    bus.req_data = (bus.req_data & ~(DW'(32'hFFFF_FFFF) << (32 * lane))) | (DW'(w) << (32 * lane));
  endtask

  function automatic logic [31:0] lane_word(input int lane);
    return 32'(bus.req_data >> (32 * lane));
  endfunction

  task automatic model_reset();
    m_ph = 0; m_rr = N_REQ - 1; m_bcnt = 0;
    m_in32 = 0; m_data = '0; m_orphan = 0;
    tag_q.delete();
    prev_in32 = 0; out8_man = 0; bus.out8 = 1'b0;
  endtask

  // One clock: check the DUT mid-cycle against the model, then advance both.
  task automatic cycle();
    logic [N_REQ-1:0] exp_rdy;
    logic [N_REQ-1:0] sh;
    int  g;
    bit  pop;
    @(negedge clk);
    exp_rdy = '0;
    g = -1;
    pop = bus.out8 && (tag_q.size() > 0) && (m_bcnt == 3);
    if (m_ph == 3 && (tag_q.size() < TAGQ_DEP || pop)) begin
      for (int k = 1; k <= N_REQ; k++) begin
        int i;
        i = (m_rr + k) % N_REQ;
        sh = bus.req_valid >> i;
        if (g < 0 && sh[0]) g = i;
      end
      if (g >= 0) exp_rdy = N_REQ'(1) << g;
    end
    if (bus.req_ready != '0) begin
      for (int i = 0; i < N_REQ; i++) begin
        sh = bus.req_ready >> i;
        if (sh[0]) dut_grants.push_back(i);
      end
    end
    if (bus.out_tag_valid === 1'b1) tv_cnt++;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("in32", 32'(bus.in32), 32'(m_in32));
    chk("in_data32", bus.in_data32, m_data);
    chk("out_tag_valid", 32'(bus.out_tag_valid), 32'(bus.out8 && tag_q.size() > 0));
    if (bus.out8 && tag_q.size() > 0) chk("out_tag", 32'(bus.out_tag), 32'(tag_q[0]));
    chk("err_orphan", 32'(bus.err_orphan), 32'(m_orphan));
    // model edge update
    if (bus.out8) begin
      if (tag_q.size() > 0) begin
        if (m_bcnt == 3) void'(tag_q.pop_front());
        m_bcnt = (m_bcnt + 1) % 4;
      end else begin
        m_orphan = 1;
      end
    end
    if (m_ph == 3) begin
      if (g >= 0) begin
        m_in32 = 1; m_data = lane_word(g); m_rr = g; tag_q.push_back(g);
      end else begin
        m_in32 = 0; m_data = '0;
      end
    end
    m_ph = (m_ph + 1) % 4;
    @(posedge clk);
    #1;
    bus.out8  = conv_en ? prev_in32 : out8_man;
    prev_in32 = bus.in32;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    rst_n = 1'b0;
    bus.out8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0, k, hi, tv0;
    checks = 0; errors = 0; tv_cnt = 0;
    conv_en = 0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in32", 32'(bus.in32), 32'd0);
    chk("rst_in_data32", bus.in_data32, 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_err_orphan", 32'(bus.err_orphan), 32'd0);
    rst_n = 1'b1;

    // T1 single word from lane 0
    conv_en = 1;
    set_word(0, 32'hAABB_CCDD);
    bus.req_valid = 4'b0001;
    n0 = dut_grants.size();
    k = 0;
    while (dut_grants.size() == n0 && k < 8) begin cycle(); k++; end
    bus.req_valid = '0;
    chk("t1_grant_cycle", 32'(k), 32'd4);
    chk("t1_grant_lane", 32'(dut_grants.size() > n0 ? dut_grants[$] : -1), 32'd0);
    chk("t1_data", bus.in_data32, 32'hAABB_CCDD);
    tv0 = tv_cnt;
    hi = 0;
    repeat (10) begin
      if (bus.in32 === 1'b1) hi++;
      cycle();
    end
    chk("t1_in32_len", 32'(hi), 32'd4);
    chk("t1_bytes", 32'(tv_cnt - tv0), 32'd4);

    // T2 fairness, all lanes valid
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_word(i, 32'(i));
    bus.req_valid = 4'b1111;
    n0 = dut_grants.size();
    k = 0;
    while (dut_grants.size() == n0 && k < 8) begin cycle(); k++; end
    hi = 0;
    repeat (16) begin
      if (bus.in32 === 1'b1) hi++;
      cycle();
    end
    bus.req_valid = '0;
    chk("t2_in32_no_gap", 32'(hi), 32'd16);
    chk("t2_grant_count", 32'(dut_grants.size() - n0), 32'd5);
    for (int j = 0; j < 5; j++)
      if (n0 + j < dut_grants.size()) chk("t2_grant_order", 32'(dut_grants[n0 + j]), 32'(j % 4));
    repeat (24) cycle();

    // T3 request raised in phase 1
    k = 0;
    while (m_ph != 1 && k < 4) begin cycle(); k++; end
    set_word(2, 32'h2222_5555);
    bus.req_valid = 4'b0100;
    k = 0;
    while (bus.in32 !== 1'b1 && k < 8) begin cycle(); k++; end
    bus.req_valid = '0;
    chk("t3_latency", 32'(k), 32'd3);
    chk("t3_grant_lane", 32'(dut_grants[$]), 32'd2);
    repeat (12) cycle();

    // T4 tag queue full with converter stalled
    conv_en = 0;
    out8_man = 0;
    set_word(1, 32'h1111_0000);
    bus.req_valid = 4'b0010;
    n0 = dut_grants.size();
    repeat (28) cycle();
    chk("t4_grants_before_full", 32'(dut_grants.size() - n0), 32'd4);
    chk("t4_in32_blocked", 32'(bus.in32), 32'd0);
    out8_man = 1;
    repeat (4) cycle();
    out8_man = 0;
    k = 0;
    while (dut_grants.size() - n0 < 5 && k < 8) begin cycle(); k++; end
    bus.req_valid = '0;
    chk("t4_grant_resumes", 32'(dut_grants.size() - n0), 32'd5);
    out8_man = 1;
    repeat (16) cycle();
    out8_man = 0;
    repeat (6) cycle();
    chk("t4_no_orphan", 32'(bus.err_orphan), 32'd0);

    // T5 orphan byte
    do_reset();
    conv_en = 0;
    out8_man = 1;
    cycle();
    out8_man = 0;
    repeat (8) cycle();
    chk("t5_orphan_sticky", 32'(bus.err_orphan), 32'd1);

    // T6 reset in phase 1 of an active frame
    do_reset();
    conv_en = 1;
    set_word(0, 32'h1234_5678);
    bus.req_valid = 4'b0001;
    k = 0;
    while (bus.in32 !== 1'b1 && k < 8) begin cycle(); k++; end
    bus.req_valid = '0;
    cycle();
    chk("t6_phase1_active", 32'(bus.in32), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_in32", 32'(bus.in32), 32'd0);
    chk("t6_async_in_data32", bus.in_data32, 32'd0);
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_word(i, 32'hC0DE_0000 | 32'(i));
    bus.req_valid = 4'b1010 | 4'b0001;
    n0 = dut_grants.size();
    k = 0;
    while (dut_grants.size() == n0 && k < 8) begin cycle(); k++; end
    bus.req_valid = '0;
    chk("t6_first_grant_cycle", 32'(k), 32'd4);
    chk("t6_first_grant_lane", 32'(dut_grants.size() > n0 ? dut_grants[$] : -1), 32'd0);
    repeat (12) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
